// File: rtl/tft_burst_reader.sv
// ---------------------------------------------------------------------------
// tft_burst_reader
//
// Upstream feeder for the TFT scan-out FIFO. Turns the display engine's
// level-style burst request into single burst-read requests on an SDRAM
// arbiter read port, counts bursts in flight, and forwards the returned
// words to the display FIFO one cycle after they arrive.
//
// aclr is tied to vertical blank, so every frame starts fully flushed.
//
// Ports
//   clkSYS       in   1    system clock, rising edge
//   aclr         in   1    asynchronous active-high reset
//   req_i        in   1    display wants another burst (level)
//   req_addr_i   in   AN   start word address of the requested burst
//   req_ack_o    out  1    one-cycle pulse: burst accepted by the arbiter
//   mem_data_o   out  DN   returned word to the display FIFO
//   mem_valid_o  out  1    mem_data_o valid (FIFO write strobe)
//   arb_req_o    out  1    burst read request to the arbiter
//   arb_addr_o   out  AN   burst start address to the arbiter
//   arb_ack_i    in   1    arbiter accepted arb_req_o (one cycle)
//   arb_data_i   in   DN   read data from the arbiter
//   arb_valid_i  in   1    arb_data_i valid
//   busy_o       out  1    a burst is pending or in flight
//   err_o        out  1    sticky: data returned with nothing in flight
//   inflight_o   out  2    bursts issued but not fully returned
// ---------------------------------------------------------------------------
module tft_burst_reader #(
    parameter int AN     = 24,
    parameter int DN     = 16,
    parameter int BURST  = 8,
    parameter int MAXOUT = 2
) (
    input  logic          clkSYS,
    input  logic          aclr,
    input  logic          req_i,
    input  logic [AN-1:0] req_addr_i,
    output logic          req_ack_o,
    output logic [DN-1:0] mem_data_o,
    output logic          mem_valid_o,
    output logic          arb_req_o,
    output logic [AN-1:0] arb_addr_o,
    input  logic          arb_ack_i,
    input  logic [DN-1:0] arb_data_i,
    input  logic          arb_valid_i,
    output logic          busy_o,
    output logic          err_o,
    output logic [1:0]    inflight_o
);

    localparam int              BW         = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0]   BEAT_LAST  = BW'(BURST - 1);
    localparam logic [1:0]      MAXOUT_L   = 2'(MAXOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic            arb_req_q,   arb_req_d;
    logic [AN-1:0]   arb_addr_q,  arb_addr_d;
    logic [DN-1:0]   mem_data_q,  mem_data_d;
    logic            mem_valid_q, mem_valid_d;
    logic [1:0]      inflight_q,  inflight_d;
    logic [BW-1:0]   beat_q,      beat_d;
    logic            err_q,       err_d;

    logic            issue_s;     // burst accepted by the arbiter this cycle
    logic            accept_s;    // returned word belongs to an in-flight burst
    logic            last_s;      // accepted word completes its burst
    logic            stray_s;     // returned word with nothing in flight

    // Request-side FSM: next state and arbiter request/address.
    always_comb begin
        state_d    = state_q;
        arb_req_d  = arb_req_q;
        arb_addr_d = arb_addr_q;
        issue_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // At MAXOUT the level request is simply not sampled.
                if (req_i && (inflight_q < MAXOUT_L)) begin
                    arb_addr_d = req_addr_i;
                    arb_req_d  = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Request and address stay stable until the arbiter accepts.
                if (arb_ack_i) begin
                    arb_req_d = 1'b0;
                    issue_s   = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    state_d   = ST_ISSUE;
                end
            end
            ST_GAP: begin
                // One dead cycle so upstream can refresh req_addr and its
                // fill level before req is looked at again.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                arb_req_d = 1'b0;
            end
        endcase
    end

    // Return-side bookkeeping: beat counter, in-flight count, data forward, error.
    always_comb begin
        accept_s    = arb_valid_i && (inflight_q != 2'd0);
        stray_s     = arb_valid_i && (inflight_q == 2'd0);
        last_s      = accept_s && (beat_q == BEAT_LAST);
        mem_data_d  = arb_data_i;
        mem_valid_d = accept_s;
        beat_d      = beat_q;
        err_d       = err_q;

        if (last_s) begin
            beat_d = {BW{1'b0}};
        end else if (accept_s) begin
            beat_d = beat_q + {{(BW-1){1'b0}}, 1'b1};
        end else begin
            beat_d = beat_q;
        end

        // Issue and completion in the same cycle cancel; neither limit can
        // be crossed since issue is gated at MAXOUT and stray beats are dropped.
        case ({issue_s, last_s})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        if (stray_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State and datapath registers; aclr flushes everything, including any aborted burst.
    always_ff @(posedge clkSYS or posedge aclr) begin
        if (aclr) begin
            state_q     <= ST_IDLE;
            arb_req_q   <= 1'b0;
            arb_addr_q  <= {AN{1'b0}};
            mem_data_q  <= {DN{1'b0}};
            mem_valid_q <= 1'b0;
            inflight_q  <= 2'd0;
            beat_q      <= {BW{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            arb_req_q   <= arb_req_d;
            arb_addr_q  <= arb_addr_d;
            mem_data_q  <= mem_data_d;
            mem_valid_q <= mem_valid_d;
            inflight_q  <= inflight_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
        end
    end

    // Acceptance pulse is combinational so it lines up with arb_ack_i.
    assign req_ack_o   = (state_q == ST_ISSUE) && arb_ack_i;
    assign busy_o      = (state_q != ST_IDLE) || (inflight_q != 2'd0);
    assign arb_req_o   = arb_req_q;
    assign arb_addr_o  = arb_addr_q;
    assign mem_data_o  = mem_data_q;
    assign mem_valid_o = mem_valid_q;
    assign inflight_o  = inflight_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_tft_burst_reader.sv
module tb_tft_burst_reader;

    logic        clkSYS;
    logic        aclr;
    logic        req_i;
    logic [23:0] req_addr_i;
    logic        req_ack_o;
    logic [15:0] mem_data_o;
    logic        mem_valid_o;
    logic        arb_req_o;
    logic [23:0] arb_addr_o;
    logic        arb_ack_i;
    logic [15:0] arb_data_i;
    logic        arb_valid_i;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  inflight_o;

    int vectors;
    int miscompares;

    tft_burst_reader #(
        .AN(24), .DN(16), .BURST(8), .MAXOUT(2)
    ) dut (
        .clkSYS      (clkSYS),
        .aclr        (aclr),
        .req_i       (req_i),
        .req_addr_i  (req_addr_i),
        .req_ack_o   (req_ack_o),
        .mem_data_o  (mem_data_o),
        .mem_valid_o (mem_valid_o),
        .arb_req_o   (arb_req_o),
        .arb_addr_o  (arb_addr_o),
        .arb_ack_i   (arb_ack_i),
        .arb_data_i  (arb_data_i),
        .arb_valid_i (arb_valid_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .inflight_o  (inflight_o)
    );

    initial clkSYS = 1'b0;
    always #5 clkSYS = ~clkSYS;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just past the next rising edge.
    task automatic cyc();
        @(posedge clkSYS);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        aclr        = 1'b1;
        req_i       = 1'b0;
        req_addr_i  = 24'h000000;
        arb_ack_i   = 1'b0;
        arb_data_i  = 16'h0000;
        arb_valid_i = 1'b0;

        // Reset state.
        #23;
        chk("rst_arb_req",   {31'd0, arb_req_o},   32'd0);
        chk("rst_arb_addr",  {8'd0, arb_addr_o},   32'd0);
        chk("rst_req_ack",   {31'd0, req_ack_o},   32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("rst_mem_data",  {16'd0, mem_data_o},  32'd0);
        chk("rst_inflight",  {30'd0, inflight_o},  32'd0);
        chk("rst_err",       {31'd0, err_o},       32'd0);
        chk("rst_busy",      {31'd0, busy_o},      32'd0);

        // Release and request burst 1 at 0x000100; arbiter acks on the third cycle.
        cyc();
        aclr       = 1'b0;
        req_i      = 1'b1;
        req_addr_i = 24'h000100;
        cyc();
        chk("b1_req_c1",  {31'd0, arb_req_o}, 32'd1);
        chk("b1_addr_c1", {8'd0, arb_addr_o}, 32'h000100);
        chk("b1_busy",    {31'd0, busy_o},    32'd1);
        chk("b1_noack",   {31'd0, req_ack_o}, 32'd0);
        cyc();
        chk("b1_req_c2",  {31'd0, arb_req_o}, 32'd1);
        chk("b1_addr_c2", {8'd0, arb_addr_o}, 32'h000100);
        cyc();
        chk("b1_req_c3",  {31'd0, arb_req_o}, 32'd1);
        arb_ack_i = 1'b1;
        #1;
        chk("b1_req_ack", {31'd0, req_ack_o}, 32'd1);
        cyc();
        arb_ack_i  = 1'b0;
        req_addr_i = 24'h000108;
        #1;
        chk("b1_ack_pulse", {31'd0, req_ack_o},  32'd0);
        chk("b1_inflight",  {30'd0, inflight_o}, 32'd1);
        chk("b1_req_drop",  {31'd0, arb_req_o},  32'd0);
        cyc();
        chk("gap_no_req", {31'd0, arb_req_o}, 32'd0);
        cyc();
        chk("b2_req",  {31'd0, arb_req_o}, 32'd1);
        chk("b2_addr", {8'd0, arb_addr_o}, 32'h000108);

        // Burst 2 acked immediately; then MAXOUT blocks further issue.
        arb_ack_i = 1'b1;
        #1;
        chk("b2_req_ack", {31'd0, req_ack_o}, 32'd1);
        cyc();
        arb_ack_i  = 1'b0;
        req_addr_i = 24'h000110;
        #1;
        chk("b2_inflight", {30'd0, inflight_o}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("max_no_req",  {31'd0, arb_req_o}, 32'd0);
            chk("max_no_ack",  {31'd0, req_ack_o}, 32'd0);
            chk("max_busy",    {31'd0, busy_o},    32'd1);
        end
        chk("max_inflight", {30'd0, inflight_o}, 32'd2);

        // Burst 1 data 0xA000..0xA007 with an idle cycle between beats.
        for (int k = 0; k < 8; k++) begin
            arb_valid_i = 1'b1;
            arb_data_i  = 16'hA000 + 16'(k);
            cyc();
            arb_valid_i = 1'b0;
            arb_data_i  = 16'h5555;
            #1;
            chk("a_mem_valid", {31'd0, mem_valid_o}, 32'd1);
            chk("a_mem_data",  {16'd0, mem_data_o},  32'hA000 + 32'(k));
            chk("a_inflight",  {30'd0, inflight_o},  (k == 7) ? 32'd1 : 32'd2);
            cyc();
            chk("a_gap_valid", {31'd0, mem_valid_o}, 32'd0);
            chk("a_gap_req",   {31'd0, arb_req_o},   (k == 7) ? 32'd1 : 32'd0);
        end
        chk("b3_addr", {8'd0, arb_addr_o}, 32'h000110);

        // Burst 2 data back-to-back while burst 3 waits in ISSUE.
        for (int k = 0; k < 7; k++) begin
            arb_valid_i = 1'b1;
            arb_data_i  = 16'hB000 + 16'(k);
            cyc();
            chk("b_mem_data", {16'd0, mem_data_o}, 32'hB000 + 32'(k));
            chk("b_inflight", {30'd0, inflight_o}, 32'd1);
            chk("b3_hold",    {31'd0, arb_req_o},  32'd1);
        end
        // Last beat of burst 2 coincides with the ack of burst 3.
        arb_data_i = 16'hB007;
        arb_ack_i  = 1'b1;
        #1;
        chk("sim_req_ack", {31'd0, req_ack_o}, 32'd1);
        cyc();
        arb_ack_i   = 1'b0;
        arb_valid_i = 1'b0;
        req_i       = 1'b0;
        #1;
        chk("sim_inflight", {30'd0, inflight_o},  32'd1);
        chk("sim_valid",    {31'd0, mem_valid_o}, 32'd1);
        chk("sim_data",     {16'd0, mem_data_o},  32'hB007);

        // Burst 3 needs a full 8 beats, proving the counter wrapped.
        for (int k = 0; k < 8; k++) begin
            arb_valid_i = 1'b1;
            arb_data_i  = 16'hC000 + 16'(k);
            cyc();
            chk("c_mem_data", {16'd0, mem_data_o}, 32'hC000 + 32'(k));
            chk("c_inflight", {30'd0, inflight_o}, (k == 7) ? 32'd0 : 32'd1);
        end
        arb_valid_i = 1'b0;
        cyc();
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_err",  {31'd0, err_o},  32'd0);

        // Stray beat with nothing in flight.
        arb_valid_i = 1'b1;
        arb_data_i  = 16'hDEAD;
        cyc();
        arb_valid_i = 1'b0;
        #1;
        chk("stray_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("stray_err",   {31'd0, err_o},       32'd1);
        cyc();
        cyc();
        chk("err_sticky", {31'd0, err_o}, 32'd1);

        // Burst at 0x200 in flight, next at 0x208 in ISSUE with 4 beats received.
        req_i      = 1'b1;
        req_addr_i = 24'h000200;
        cyc();
        arb_ack_i = 1'b1;
        cyc();
        arb_ack_i  = 1'b0;
        req_addr_i = 24'h000208;
        cyc();
        cyc();
        chk("d_addr", {8'd0, arb_addr_o}, 32'h000208);
        for (int k = 0; k < 4; k++) begin
            arb_valid_i = 1'b1;
            arb_data_i  = 16'hD000 + 16'(k);
            cyc();
        end
        arb_valid_i = 1'b0;
        chk("d_inflight", {30'd0, inflight_o}, 32'd1);
        chk("d_issue",    {31'd0, arb_req_o},  32'd1);

        // Asynchronous clear mid-cycle.
        #2;
        aclr = 1'b1;
        #1;
        chk("aclr_arb_req",   {31'd0, arb_req_o},   32'd0);
        chk("aclr_arb_addr",  {8'd0, arb_addr_o},   32'd0);
        chk("aclr_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("aclr_mem_data",  {16'd0, mem_data_o},  32'd0);
        chk("aclr_inflight",  {30'd0, inflight_o},  32'd0);
        chk("aclr_err",       {31'd0, err_o},       32'd0);
        chk("aclr_busy",      {31'd0, busy_o},      32'd0);

        // Fresh burst after release must again take exactly 8 beats.
        cyc();
        aclr       = 1'b0;
        req_addr_i = 24'h000300;
        cyc();
        chk("e_req",  {31'd0, arb_req_o}, 32'd1);
        chk("e_addr", {8'd0, arb_addr_o}, 32'h000300);
        arb_ack_i = 1'b1;
        cyc();
        arb_ack_i = 1'b0;
        req_i     = 1'b0;
        #1;
        chk("e_inflight", {30'd0, inflight_o}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            arb_valid_i = 1'b1;
            arb_data_i  = 16'hE000 + 16'(k);
            cyc();
            chk("e_mem_data", {16'd0, mem_data_o}, 32'hE000 + 32'(k));
            chk("e_cnt",      {30'd0, inflight_o}, (k == 7) ? 32'd0 : 32'd1);
        end
        arb_valid_i = 1'b0;
        cyc();
        chk("e_err",  {31'd0, err_o},  32'd0);
        chk("e_busy", {31'd0, busy_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
